// File: rtl/ones_count_seq.sv
// Burst sequencer around a combinational byte popcount: pulls LEN bytes over
// valid/ready, sums their ones and tracks the largest per-byte count.

module ones_count (
  input  logic [7:0] dat_in,
  output logic [3:0] count
);

  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns a default first, so no latch is inferred.
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, dat_in[i]};
    end
  end

endmodule

module ones_count_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = LEN_W + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] total,
  output logic [3:0]       max_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q;
  logic [ACC_W-1:0]   total_q;
  logic [3:0]         max_q;
  logic               busy_q;
  logic [3:0]         byte_cnt;
  logic               accept;

  ones_count u_ones_count (
    .dat_in (in_data),
    .count  (byte_cnt)
  );

  // in_ready depends only on state and abort, never on in_valid.
  assign in_ready = (state_q == RUN) && !abort;
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort)                                  state_d = IDLE;
        else if (accept && remaining_q == LEN_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here is small control/datapath state, so all of it is reset; sequential state uses '<='.
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      remaining_q <= '0;
      total_q     <= '0;
      max_q       <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (start) begin
            remaining_q <= len;
            total_q     <= '0;
            max_q       <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            total_q <= '0;
            max_q   <= '0;
          end else if (accept) begin
            total_q     <= total_q + ACC_W'(byte_cnt);
            max_q       <= (byte_cnt > max_q) ? byte_cnt : max_q;
            remaining_q <= remaining_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = (state_q == DONE);
  assign total   = total_q;
  assign max_cnt = max_q;

endmodule
